// File: rtl/data_memory_responder.sv
// data_memory_responder: memory-side responder for the S-Machine CPU data port.
// Serves loads and stores against an internal 2**ADDR_WIDTH x DATA_WIDTH store.
// Stores are posted into a FIFO write buffer that retires one entry per edge.
// Loads return after READ_LATENCY edges, with buffered store data forwarded.
//
// Ports:
//   clk                system clock, rising-edge active
//   reset              asynchronous, active-high reset
//   req_valid          CPU presents a request this cycle
//   read_write_memory  1 = store, 0 = load
//   addr               word address of the request
//   data_out_memory    store data from the CPU
//   ready              request can be accepted this cycle (combinational)
//   data_in_memory     load result (registered, held until next response)
//   rdata_valid        one-cycle pulse marking a load result
//   idle               FSM idle and write buffer empty (combinational)
module data_memory_responder #(
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WBUF_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  read_write_memory,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_out_memory,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_in_memory,
  output logic                  rdata_valid,
  output logic                  idle
);

  localparam int unsigned MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LAT_W     = 3;
  localparam int unsigned WB_CNT_W  = $clog2(WBUF_DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [LAT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] rd_hold;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  resp_fire;

  // Data store: contents start at zero and are not touched by reset.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

  // Write buffer, entry 0 is the oldest.
  logic [ADDR_WIDTH-1:0] wb_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data [WBUF_DEPTH];
  logic [WB_CNT_W-1:0]   wb_count;

  logic                  rd_accept;
  logic                  wr_accept;
  logic                  drain;
  logic [WB_CNT_W-1:0]   push_idx;

  assign rd_accept = req_valid && ready && !read_write_memory;
  assign wr_accept = req_valid && ready && read_write_memory;
  assign drain     = (wb_count != '0);
  // Slot the new entry lands in after this edge's drain shift.
  assign push_idx  = wb_count - WB_CNT_W'(drain);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd_accept) state_next = BUSY;
      BUSY:    if (cnt == LAT_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    ready     = 1'b0;
    idle      = 1'b0;
    resp_fire = 1'b0;
    ready     = (state == IDLE) && (wb_count < WB_CNT_W'(WBUF_DEPTH));
    idle      = (state == IDLE) && (wb_count == '0);
    resp_fire = (state == BUSY) && (cnt == LAT_W'(1));
  end

  // Load value: youngest matching buffered store, else the store contents.
  // Includes the entry retiring on this same edge.
  always_comb begin
    fwd_data = mem[addr];
    for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
      if ((WB_CNT_W'(i) < wb_count) && (wb_addr[i] == addr)) begin
        fwd_data = wb_data[i];
      end
    end
  end

  // Load latency counter, captured value and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      rd_hold        <= '0;
      rdata_valid    <= 1'b0;
      data_in_memory <= '0;
    end else begin
      rdata_valid <= resp_fire;
      if (resp_fire) begin
        data_in_memory <= rd_hold;
      end
      if (rd_accept) begin
        cnt     <= LAT_W'(READ_LATENCY);
        rd_hold <= fwd_data;
      end else if (state == BUSY) begin
        cnt <= cnt - LAT_W'(1);
      end
    end
  end

  // Write buffer occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_count <= '0;
    end else begin
      case ({wr_accept, drain})
        2'b10:   wb_count <= wb_count + WB_CNT_W'(1);
        2'b01:   wb_count <= wb_count - WB_CNT_W'(1);
        default: wb_count <= wb_count;
      endcase
    end
  end

  // Write buffer payload: shift on drain, then place the new entry.
  always_ff @(posedge clk) begin
    if (drain) begin
      for (int i = 0; i + 1 < int'(WBUF_DEPTH); i++) begin
        wb_addr[i] <= wb_addr[i+1];
        wb_data[i] <= wb_data[i+1];
      end
    end
    for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
      if (wr_accept && (WB_CNT_W'(i) == push_idx)) begin
        wb_addr[i] <= addr;
        wb_data[i] <= data_out_memory;
      end
    end
  end

  // Retire the oldest buffered store into the data store.
  always_ff @(posedge clk) begin
    if (drain) begin
      mem[wb_addr[0]] <= wb_data[0];
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed stimulus, a queue-based reference
// model checked every cycle, plus literal expectations on key results.
module tb_data_memory_responder;

  localparam int AW   = 9;
  localparam int DW   = 16;
  localparam int LAT  = 2;
  localparam int WBUF = 2;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          read_write_memory;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out_memory;
  logic          ready;
  logic [DW-1:0] data_in_memory;
  logic          rdata_valid;
  logic          idle;

  int tests = 0;
  int fails = 0;
  bit run_cmp = 0;

  data_memory_responder #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(LAT),
    .WBUF_DEPTH  (WBUF)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .read_write_memory(read_write_memory),
    .addr             (addr),
    .data_out_memory  (data_out_memory),
    .ready            (ready),
    .data_in_memory   (data_in_memory),
    .rdata_valid      (rdata_valid),
    .idle             (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  logic [DW-1:0] mmem [1 << AW];
  bit            m_busy = 0;
  int            m_resp_at = 0;
  int            cyc = 0;
  logic [DW-1:0] m_cap = '0;
  bit            m_rv = 0;
  logic [DW-1:0] m_dout = '0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mmem[i] = '0;
  end

  function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mmem[a];
    foreach (wq[i]) if (wq[i].a == a) v = wq[i].d;
    return v;
  endfunction

  function automatic bit m_ready();
    return !m_busy && (wq.size() < WBUF);
  endfunction

  function automatic bit m_idle();
    return !m_busy && (wq.size() == 0);
  endfunction

  always @(posedge clk) begin
    bit  acc;
    wr_t e;
    cyc++;
    if (reset) begin
      m_busy = 0;
      wq.delete();
      m_rv   = 0;
      m_dout = '0;
    end else begin
      acc  = req_valid && m_ready();
      m_rv = 0;
      if (m_busy && cyc == m_resp_at) begin
        m_rv   = 1;
        m_dout = m_cap;
        m_busy = 0;
      end
      if (acc && !read_write_memory) begin
        m_cap     = lookup(addr);
        m_resp_at = cyc + LAT;
        m_busy    = 1;
      end
      if (wq.size() > 0) begin
        mmem[wq[0].a] = wq[0].d;
        void'(wq.pop_front());
      end
      if (acc && read_write_memory) begin
        e.a = addr;
        e.d = data_out_memory;
        wq.push_back(e);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always begin
    @(posedge clk);
    #1;
    if (run_cmp) begin
      check("cmp_ready", 32'(ready), 32'(m_ready()));
      check("cmp_idle", 32'(idle), 32'(m_idle()));
      check("cmp_rdata_valid", 32'(rdata_valid), 32'(m_rv));
      check("cmp_data_in_memory", 32'(data_in_memory), 32'(m_dout));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ready) check("issue_ready_timeout", 32'(ready), 32'd1);
    req_valid         = 1'b1;
    read_write_memory = rw;
    addr              = a;
    data_out_memory   = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input logic [DW-1:0] exp, input int exp_lat);
    bit got;
    got = 0;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(posedge clk);
      #2;
      if (rdata_valid) begin
        got = 1;
        check({name, "_latency"}, 32'(k), 32'(exp_lat));
        check({name, "_data"}, 32'(data_in_memory), 32'(exp));
      end
    end
    if (!got) check({name, "_timeout"}, 32'(rdata_valid), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset             = 1'b0;
    req_valid         = 1'b0;
    read_write_memory = 1'b0;
    addr              = '0;
    data_out_memory   = '0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_rdata_valid", 32'(rdata_valid), 32'd0);
    check("reset_data", 32'(data_in_memory), 32'd0);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_idle", 32'(idle), 32'd1);
    run_cmp = 1;

    // Basic load of a preloaded word.
    issue(1'b1, 9'h005, 16'hBEEF);
    repeat (2) @(posedge clk);
    issue(1'b0, 9'h005, 16'h0);
    check("basic_ready_low", 32'(ready), 32'd0);
    wait_resp("basic_load", 16'hBEEF, LAT);

    // Store then immediate load forwards the store data.
    issue(1'b1, 9'h0A0, 16'h1234);
    issue(1'b0, 9'h0A0, 16'h0);
    wait_resp("forward", 16'h1234, LAT);

    // Youngest store wins, then the store holds it.
    issue(1'b1, 9'h003, 16'h1111);
    issue(1'b1, 9'h003, 16'h2222);
    issue(1'b0, 9'h003, 16'h0);
    wait_resp("youngest", 16'h2222, LAT);
    repeat (3) @(posedge clk);
    issue(1'b0, 9'h003, 16'h0);
    wait_resp("youngest_mem", 16'h2222, LAT);

    // Continuous stores: one accepted per edge, ready stays high.
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, AW'(9'h100 + i), DW'(16'hA000 + i));
      check("stream_ready", 32'(ready), 32'd1);
      check("stream_idle_low", 32'(idle), 32'd0);
    end
    @(posedge clk);
    #1;
    check("stream_idle_after", 32'(idle), 32'd1);
    issue(1'b0, 9'h105, 16'h0);
    wait_resp("stream_last", 16'hA005, LAT);

    // Reset discards an undrained store.
    issue(1'b1, 9'h0F0, 16'h5555);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 9'h0F0, 16'h0);
    wait_resp("discarded_store", 16'h0000, LAT);

    // Reset during a pending load drops the response.
    issue(1'b0, 9'h005, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #2;
      check("rst_no_valid", 32'(rdata_valid), 32'd0);
    end
    check("rst_data_zero", 32'(data_in_memory), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);

    // Top address and address zero are independent.
    issue(1'b1, 9'h1FF, 16'hCAFE);
    issue(1'b0, 9'h1FF, 16'h0);
    wait_resp("top_addr", 16'hCAFE, LAT);
    issue(1'b0, 9'h000, 16'h0);
    wait_resp("addr_zero", 16'h0000, LAT);

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
